// File: rtl/pll_lock_supervisor_if.sv
// Bundle of the PLL-side and downstream-side signals of the lock supervisor.
// The supervisor connects through the master modport; the PLL model or
// the consumer of the resets connects through the slave modport.
//
// Signalling: there is no valid/ready handshake on this bundle. Every
// signal is a level. pll_lock_i is asynchronous to clk and is synchronized
// inside the supervisor. All outputs come straight from clk-domain flops
// and may be sampled on any clk edge. state_o is a debug view of the FSM.
interface pll_lock_supervisor_if;
  logic       pll_lock_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;
  logic [2:0] state_o;

  modport master (
    input  pll_lock_i,
    output pll_rst_o, sys_rst_o, locked_o, fault_o, retry_cnt_o, loss_cnt_o, state_o
  );

  modport slave (
    output pll_lock_i,
    input  pll_rst_o, sys_rst_o, locked_o, fault_o, retry_cnt_o, loss_cnt_o, state_o
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the rPLL RESET, qualifies its LOCK output and
// generates the downstream synchronous reset for the TMDS/HDMI logic.
// Optional feature macro: LOCK_LOSS_COUNT_EN builds the RUN lock-loss counter;
// without it loss_cnt_o is tied to zero.
//
// Qualification timing: lock_s must be seen high for STABLE_CYCLES contiguous
// cycles, the first being the WAIT_LOCK cycle that detects it, so STABLE
// itself lasts STABLE_CYCLES-1 cycles (minimum one). HOLD then lasts
// HOLD_CYCLES cycles (>=1). From pll_lock_i going high right after edge k,
// sys_rst_o falls at edge k + SYNC_STAGES + STABLE_CYCLES + HOLD_CYCLES.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 27,
  parameter int LOCK_TIMEOUT   = 27000,
  parameter int STABLE_CYCLES  = 2700,
  parameter int HOLD_CYCLES    = 270,
  parameter int MAX_RETRIES    = 3
) (
  input logic                   clk,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  localparam logic [2:0] ST_PLLRST = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam int RST_LAST  = PLL_RST_CYCLES - 1;
  localparam int TO_LAST   = LOCK_TIMEOUT - 1;
  localparam int STB_LAST  = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0;
  localparam int HOLD_LAST = HOLD_CYCLES - 1;

  localparam int T_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_B    = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int T_MAX  = (T_A > T_B) ? T_A : T_B;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  logic [2:0]             state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [3:0]             retry_cnt_q, retry_cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   locked_q, locked_d;
  logic                   fault_q, fault_d;
  logic                   run_loss;

  // Shift the asynchronous LOCK through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_lock_i};
  end

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign run_loss = (state_q == ST_RUN) && !lock_s;

  // Bring-up sequencing: PLL reset, lock wait with retries, qualification, run.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      ST_PLLRST: begin
        if (timer_q == TMR_W'(RST_LAST)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A lock seen on the expiry cycle takes priority over the retry.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == TMR_W'(TO_LAST)) begin
          if (retry_cnt_q < 4'(MAX_RETRIES)) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            state_d     = ST_PLLRST;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) state_d = ST_WAIT;
        else if (timer_q == TMR_W'(STB_LAST)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_s) state_d = ST_WAIT;
        else if (timer_q == TMR_W'(HOLD_LAST)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_PLLRST;
          retry_cnt_d = 4'd0;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_PLLRST;
      end
    endcase
  end

  // Single shared timer: restarts on every state change, saturates otherwise.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (timer_q != {TMR_W{1'b1}}) timer_d = timer_q + TMR_W'(1);
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    pll_rst_d = (state_d == ST_PLLRST);
    sys_rst_d = (state_d != ST_RUN);
    locked_d  = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= ST_PLLRST;
      timer_q     <= '0;
      retry_cnt_q <= 4'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Count lock losses seen while running, saturating at 255.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (run_loss && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  // Lock-loss counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_cnt_q <= 8'd0;
    else     loss_cnt_q <= loss_cnt_d;
  end

  assign bus.loss_cnt_o = loss_cnt_q;
`else
  logic unused_run_loss;
  assign unused_run_loss = run_loss;
  assign bus.loss_cnt_o  = 8'd0;
`endif

  assign bus.pll_rst_o   = pll_rst_q;
  assign bus.sys_rst_o   = sys_rst_q;
  assign bus.locked_o    = locked_q;
  assign bus.fault_o     = fault_q;
  assign bus.retry_cnt_o = retry_cnt_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short bench timing:
// PLL_RST_CYCLES=3, LOCK_TIMEOUT=20, STABLE_CYCLES=8, HOLD_CYCLES=4,
// MAX_RETRIES=2, SYNC_STAGES=2. Edge numbers count posedges after reset
// release; "lock driven after edge k" means pll_lock_i changes 1 time unit
// after edge k. Honours LOCK_LOSS_COUNT_EN for the loss counter expectation.
module tb_pll_lock_supervisor;

  localparam logic [2:0] ST_PLLRST = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  logic clk;
  logic rst;
  int   cyc;
  int   n_total;
  int   n_bad;
  logic loss_en;
  logic [3:0] exp_q[$];

  pll_lock_supervisor_if bus_if ();

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(3),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .MAX_RETRIES   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_locked(input logic want, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus_if.locked_o == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_pll_rst"}, 32'(bus_if.pll_rst_o), 1);
    check_val({tag, "_sys_rst"}, 32'(bus_if.sys_rst_o), 1);
    check_val({tag, "_locked"},  32'(bus_if.locked_o), 0);
    check_val({tag, "_fault"},   32'(bus_if.fault_o), 0);
    check_val({tag, "_retry"},   32'(bus_if.retry_cnt_o), 0);
    check_val({tag, "_state"},   32'(bus_if.state_o), 32'(ST_PLLRST));
  endtask

  function automatic int exp_loss(input int n);
    if (!loss_en) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  initial begin
    logic       ok;
    logic [3:0] prev_retry;
    logic       prev_pll;
    int         pll_high;
    int         pll_rises;
    int         early;
    int         losses;

    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
`ifdef LOCK_LOSS_COUNT_EN
    loss_en = 1'b1;
`else
    loss_en = 1'b0;
`endif
    bus_if.pll_lock_i = 1'b0;
    rst = 1'b1;

    // Reset state
    tick();
    check_reset_values("rst");
    check_val("rst_loss", 32'(bus_if.loss_cnt_o), 0);

    // Lock at edge 10 and held: pll_rst_o falls at edge 3, release at 10+14
    apply_reset();
    run_to(2);
    check_val("t1_pll_rst_hi", 32'(bus_if.pll_rst_o), 1);
    run_to(3);
    check_val("t1_pll_rst_lo", 32'(bus_if.pll_rst_o), 0);
    run_to(10);
    bus_if.pll_lock_i = 1'b1;
    run_to(23);
    check_val("t1_sys_rst_pre", 32'(bus_if.sys_rst_o), 1);
    run_to(24);
    check_val("t1_sys_rst_rel", 32'(bus_if.sys_rst_o), 0);
    check_val("t1_locked", 32'(bus_if.locked_o), 1);

    // RUN lock drop for one cycle after edge 30: reset back at edge 33, RUN at 48
    run_to(30);
    bus_if.pll_lock_i = 1'b0;
    run_to(31);
    bus_if.pll_lock_i = 1'b1;
    run_to(32);
    check_val("t4_sys_rst_still_lo", 32'(bus_if.sys_rst_o), 0);
    run_to(33);
    check_val("t4_sys_rst_hi", 32'(bus_if.sys_rst_o), 1);
    check_val("t4_locked_lo", 32'(bus_if.locked_o), 0);
    check_val("t4_pll_rst_hi", 32'(bus_if.pll_rst_o), 1);
    check_val("t4_loss", 32'(bus_if.loss_cnt_o), 32'(exp_loss(1)));
    run_to(47);
    check_val("t4_rerun_pre", 32'(bus_if.sys_rst_o), 1);
    run_to(48);
    check_val("t4_rerun_rel", 32'(bus_if.sys_rst_o), 0);
    check_val("t4_rerun_locked", 32'(bus_if.locked_o), 1);

    // No lock ever: three 3-cycle PLL reset pulses, retries 1,2, FAULT at edge 69
    bus_if.pll_lock_i = 1'b0;
    apply_reset();
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    prev_retry = 4'd0;
    prev_pll   = bus_if.pll_rst_o;
    pll_high   = bus_if.pll_rst_o ? 1 : 0;
    pll_rises  = bus_if.pll_rst_o ? 1 : 0;
    while (cyc < 69) begin
      tick();
      if (bus_if.retry_cnt_o != prev_retry) begin
        if (exp_q.size() == 0) check_val("t2_retry_extra", 32'(bus_if.retry_cnt_o), 32'(prev_retry));
        else check_val("t2_retry_step", 32'(bus_if.retry_cnt_o), 32'(exp_q.pop_front()));
        prev_retry = bus_if.retry_cnt_o;
      end
      if (bus_if.pll_rst_o) pll_high++;
      if (bus_if.pll_rst_o && !prev_pll) pll_rises++;
      prev_pll = bus_if.pll_rst_o;
      if (cyc == 68) check_val("t2_fault_pre", 32'(bus_if.fault_o), 0);
    end
    check_val("t2_retry_left", 32'(exp_q.size()), 0);
    check_val("t2_pll_pulses", 32'(pll_rises), 3);
    check_val("t2_pll_high_cycles", 32'(pll_high), 9);
    check_val("t2_fault", 32'(bus_if.fault_o), 1);
    check_val("t2_pll_rst_fault", 32'(bus_if.pll_rst_o), 0);
    check_val("t2_sys_rst_fault", 32'(bus_if.sys_rst_o), 1);
    check_val("t2_retry_fault", 32'(bus_if.retry_cnt_o), 2);
    check_val("t2_state_fault", 32'(bus_if.state_o), 32'(ST_FAULT));
    run_to(70);
    bus_if.pll_lock_i = 1'b1;
    run_to(100);
    check_val("t2_fault_sticky", 32'(bus_if.fault_o), 1);
    check_val("t2_sys_rst_sticky", 32'(bus_if.sys_rst_o), 1);
    check_val("t2_locked_sticky", 32'(bus_if.locked_o), 0);
    // Asynchronous reset in FAULT
    rst = 1'b1;
    #1;
    check_reset_values("t6_fault_rst");

    // Lock arrives on the timeout cycle of the second wait (retry_cnt=1)
    bus_if.pll_lock_i = 1'b0;
    apply_reset();
    run_to(43);
    bus_if.pll_lock_i = 1'b1;
    run_to(45);
    check_val("t5_state_wait", 32'(bus_if.state_o), 32'(ST_WAIT));
    check_val("t5_retry_pre", 32'(bus_if.retry_cnt_o), 1);
    run_to(46);
    check_val("t5_state_stable", 32'(bus_if.state_o), 32'(ST_STABLE));
    check_val("t5_retry_kept", 32'(bus_if.retry_cnt_o), 1);
    check_val("t5_pll_rst_lo", 32'(bus_if.pll_rst_o), 0);
    run_to(56);
    check_val("t5_sys_rst_pre", 32'(bus_if.sys_rst_o), 1);
    run_to(57);
    check_val("t5_sys_rst_rel", 32'(bus_if.sys_rst_o), 0);
    check_val("t5_retry_run", 32'(bus_if.retry_cnt_o), 1);
    // Loss in RUN clears the retry count
    run_to(60);
    bus_if.pll_lock_i = 1'b0;
    run_to(61);
    bus_if.pll_lock_i = 1'b1;
    run_to(62);
    check_val("t4b_sys_rst_lo", 32'(bus_if.sys_rst_o), 0);
    run_to(63);
    check_val("t4b_sys_rst_hi", 32'(bus_if.sys_rst_o), 1);
    check_val("t4b_retry_clr", 32'(bus_if.retry_cnt_o), 0);
    check_val("t4b_loss", 32'(bus_if.loss_cnt_o), 32'(exp_loss(1)));
    run_to(66);
    check_val("t4b_pll_rst_lo", 32'(bus_if.pll_rst_o), 0);
    run_to(77);
    check_val("t4b_rerun_pre", 32'(bus_if.sys_rst_o), 1);
    run_to(78);
    check_val("t4b_rerun_rel", 32'(bus_if.sys_rst_o), 0);
    check_val("t4b_rerun_locked", 32'(bus_if.locked_o), 1);

    // Lock high 5 cycles, low 1, then high: release only at 16+14 = edge 30
    bus_if.pll_lock_i = 1'b0;
    apply_reset();
    early = 0;
    while (cyc < 29) begin
      if (cyc == 10) bus_if.pll_lock_i = 1'b1;
      if (cyc == 15) bus_if.pll_lock_i = 1'b0;
      if (cyc == 16) bus_if.pll_lock_i = 1'b1;
      tick();
      if (!bus_if.sys_rst_o) early++;
      if (cyc == 13) check_val("t3_state_stable1", 32'(bus_if.state_o), 32'(ST_STABLE));
      if (cyc == 18) check_val("t3_state_back_wait", 32'(bus_if.state_o), 32'(ST_WAIT));
      if (cyc == 19) check_val("t3_state_stable2", 32'(bus_if.state_o), 32'(ST_STABLE));
      if (cyc == 26) check_val("t3_state_hold", 32'(bus_if.state_o), 32'(ST_HOLD));
    end
    check_val("t3_no_early_release", 32'(early), 0);
    run_to(30);
    check_val("t3_sys_rst_rel", 32'(bus_if.sys_rst_o), 0);
    check_val("t3_locked", 32'(bus_if.locked_o), 1);

    // Asynchronous reset while in HOLD
    bus_if.pll_lock_i = 1'b0;
    apply_reset();
    run_to(10);
    bus_if.pll_lock_i = 1'b1;
    run_to(22);
    check_val("t6_state_hold", 32'(bus_if.state_o), 32'(ST_HOLD));
    rst = 1'b1;
    #1;
    check_reset_values("t6_hold_rst");

    // 300 forced lock losses in RUN: counter saturates at 255
    apply_reset();
    losses = 0;
    for (int i = 0; i < 300; i++) begin
      wait_locked(1'b1, 60, ok);
      if (!ok) begin
        check_val("t6_relock_timeout", 32'(ok), 1);
        break;
      end
      bus_if.pll_lock_i = 1'b0;
      tick();
      bus_if.pll_lock_i = 1'b1;
      wait_locked(1'b0, 10, ok);
      if (!ok) begin
        check_val("t6_drop_timeout", 32'(ok), 1);
        break;
      end
      losses++;
      if (losses == 100) check_val("t6_loss_100", 32'(bus_if.loss_cnt_o), 32'(exp_loss(100)));
    end
    check_val("t6_loss_count_done", 32'(losses), 300);
    check_val("t6_loss_sat", 32'(bus_if.loss_cnt_o), 32'(exp_loss(300)));
    wait_locked(1'b1, 60, ok);
    check_val("t6_final_relock", 32'(ok), 1);
    check_val("t6_loss_sat_hold", 32'(bus_if.loss_cnt_o), 32'(exp_loss(300)));

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
